// File: rtl/ifft_frame_packer.sv
// ---------------------------------------------------------------------------
// ifft_frame_packer
//
// Sits after the 2048-point inverse FFT core. It takes the core's
// i_ce-strobed complex output stream and frame sync, and for each sample:
//   - rounds and saturates each component from IWIDTH to OWIDTH bits,
//   - numbers the sample within its frame,
//   - buffers it in a small first-word-fall-through FIFO.
// Frames leave on a valid/ready stream, with o_last marking the final sample.
//
// Ports:
//   i_clk       clock, all logic on the rising edge
//   i_reset     asynchronous, active-high reset
//   i_ce        input sample strobe (same strobe that drives the FFT core)
//   i_sample    {real, imag}, each IWIDTH-bit two's complement
//   i_sync      high with i_ce on sample 0 of a frame
//   i_clear     synchronous clear of the sticky flags
//   o_valid     output word available
//   i_ready     consumer accepts the word when o_valid && i_ready
//   o_data      {real, imag}, each OWIDTH-bit rounded/saturated
//   o_last      o_data is sample 2^LGSIZE-1 of its frame
//   o_overflow  sticky: a sample was dropped because the FIFO was full
//   o_sat       sticky: a component saturated
// ---------------------------------------------------------------------------
module ifft_frame_packer #(
  parameter int IWIDTH = 28,
  parameter int OWIDTH = 16,
  parameter int SHIFT  = 0,
  parameter int LGSIZE = 11,
  parameter int LGFIFO = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_ce,
  input  logic [2*IWIDTH-1:0]   i_sample,
  input  logic                  i_sync,
  input  logic                  i_clear,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [2*OWIDTH-1:0]   o_data,
  output logic                  o_last,
  output logic                  o_overflow,
  output logic                  o_sat
);

  localparam int DROP   = IWIDTH - OWIDTH;
  localparam int TWIDTH = IWIDTH + SHIFT;
  localparam int DEPTH  = 1 << LGFIFO;

  // One bit of headroom above the shifted value, so the rounding add can
  // never wrap.
  localparam logic signed [TWIDTH:0] HALF_M1 = (TWIDTH+1)'((1 << (DROP-1)) - 1);
  localparam logic signed [TWIDTH:0] MAXV    = (TWIDTH+1)'((1 << (OWIDTH-1)) - 1);
  localparam logic signed [TWIDTH:0] MINV    = (TWIDTH+1)'(-(1 << (OWIDTH-1)));

  typedef enum logic [0:0] {
    S_WAIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Gain shift, convergent rounding (round half to even), then clamping.
  // Returns {saturated, value}.
  function automatic logic [OWIDTH:0] roundSat(input logic [IWIDTH-1:0] v);
    logic signed [TWIDTH:0] t;
    logic signed [TWIDTH:0] sum;
    logic signed [TWIDTH:0] q;
    logic [OWIDTH:0]        res;
    t   = {{(SHIFT+1){v[IWIDTH-1]}}, v} <<< SHIFT;
    // Adding half-minus-one plus the kept LSB rounds ties toward even.
    sum = t + HALF_M1 + {{TWIDTH{1'b0}}, t[DROP]};
    q   = sum >>> DROP;
    if (q > MAXV) begin
      res = {1'b1, MAXV[OWIDTH-1:0]};
    end else if (q < MINV) begin
      res = {1'b1, MINV[OWIDTH-1:0]};
    end else begin
      res = {1'b0, q[OWIDTH-1:0]};
    end
    return res;
  endfunction

  state_t                r_state;
  state_t                w_nextState;
  logic [LGSIZE-1:0]     r_count;
  logic [LGSIZE-1:0]     w_index;
  logic                  w_accept;
  logic                  w_isLast;

  logic [OWIDTH:0]       w_reRes;
  logic [OWIDTH:0]       w_imRes;
  logic                  w_satNow;

  logic                  r_s1Valid;
  logic [2*OWIDTH-1:0]   r_s1Data;
  logic                  r_s1Last;

  logic [2*OWIDTH:0]     r_mem [DEPTH];
  logic [LGFIFO-1:0]     r_wrPtr;
  logic [LGFIFO-1:0]     r_rdPtr;
  logic [LGFIFO:0]       r_memCount;
  logic [LGFIFO:0]       w_total;
  logic                  w_full;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_load;
  logic                  w_pop;

  logic                  r_outValid;
  logic [2*OWIDTH-1:0]   r_outData;
  logic                  r_outLast;
  logic                  r_overflow;
  logic                  r_sat;

  assign w_reRes  = roundSat(i_sample[2*IWIDTH-1:IWIDTH]);
  assign w_imRes  = roundSat(i_sample[IWIDTH-1:0]);
  assign w_satNow = w_reRes[OWIDTH] | w_imRes[OWIDTH];

  // Frame-alignment state register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_WAIT;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and acceptance logic. A sync always restarts the index at 0,
  // even mid-frame; the interrupted frame then ends without o_last.
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_index     = r_count;
    case (r_state)
      S_WAIT: begin
        if (i_ce && i_sync) begin
          w_accept    = 1'b1;
          w_index     = '0;
          w_nextState = S_RUN;
        end
      end
      S_RUN: begin
        if (i_ce) begin
          w_accept = 1'b1;
          if (i_sync) begin
            w_index = '0;
          end
        end
      end
      default: begin
        w_nextState = S_WAIT;
      end
    endcase
  end

  assign w_isLast = &w_index;

  // The sample counter advances on every accepted sample, including those
  // that are later dropped by a full FIFO, so indices stay aligned.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (w_accept) begin
      r_count <= w_index + LGSIZE'(1);
    end
  end

  // Stage 1: capture the rounded sample and its last tag at the same edge
  // that accepts it.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_s1Valid <= 1'b0;
      r_s1Data  <= '0;
      r_s1Last  <= 1'b0;
    end else begin
      r_s1Valid <= w_accept;
      if (w_accept) begin
        r_s1Data <= {w_reRes[OWIDTH-1:0], w_imRes[OWIDTH-1:0]};
        r_s1Last <= w_isLast;
      end
    end
  end

  // Occupancy counts the memory plus the output register. Fullness is
  // judged from registered state only, so a same-cycle pop never rescues
  // a push and i_ready never gates a push combinationally.
  assign w_total = r_memCount + {{LGFIFO{1'b0}}, r_outValid};
  assign w_full  = (w_total == (LGFIFO+1)'(DEPTH));
  assign w_push  = r_s1Valid && !w_full;
  assign w_drop  = r_s1Valid && w_full;
  assign w_pop   = r_outValid && i_ready;
  assign w_load  = (r_memCount != '0) && (!r_outValid || i_ready);

  // FIFO storage. Holds no reset; only pointers and counts need one.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= {r_s1Data, r_s1Last};
    end
  end

  // Pointers and memory occupancy. Push and load in the same cycle leave
  // the count unchanged.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_memCount <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + LGFIFO'(1);
      end
      if (w_load) begin
        r_rdPtr <= r_rdPtr + LGFIFO'(1);
      end
      case ({w_push, w_load})
        2'b10:   r_memCount <= r_memCount + (LGFIFO+1)'(1);
        2'b01:   r_memCount <= r_memCount - (LGFIFO+1)'(1);
        default: r_memCount <= r_memCount;
      endcase
    end
  end

  // Registered FWFT output. It refills whenever it is empty or being
  // consumed, and it holds its word while stalled.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_outValid <= 1'b0;
      r_outData  <= '0;
      r_outLast  <= 1'b0;
    end else if (w_load) begin
      r_outValid <= 1'b1;
      r_outData  <= r_mem[r_rdPtr][2*OWIDTH:1];
      r_outLast  <= r_mem[r_rdPtr][0];
    end else if (w_pop) begin
      r_outValid <= 1'b0;
    end
  end

  // Sticky flags. A clear wins over a set in the same cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_overflow <= 1'b0;
      r_sat      <= 1'b0;
    end else begin
      if (i_clear) begin
        r_overflow <= 1'b0;
      end else if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (i_clear) begin
        r_sat <= 1'b0;
      end else if (w_accept && w_satNow) begin
        r_sat <= 1'b1;
      end
    end
  end

  assign o_valid    = r_outValid;
  assign o_data     = r_outData;
  assign o_last     = r_outLast;
  assign o_overflow = r_overflow;
  assign o_sat      = r_sat;

endmodule

// File: tb/tb_ifft_frame_packer.sv
// ---------------------------------------------------------------------------
// Testbench for ifft_frame_packer. Two instances share the stimulus: the
// default one (SHIFT=0) and a gain-shifted one (SHIFT=1). Observed output
// words are collected into queues and compared with hand-computed values.
// ---------------------------------------------------------------------------
module tb_ifft_frame_packer;

  logic        clk;
  logic        i_reset;
  logic        i_ce;
  logic [55:0] i_sample;
  logic        i_sync;
  logic        i_clear;
  logic        i_ready;

  logic        o_valid;
  logic [31:0] o_data;
  logic        o_last;
  logic        o_overflow;
  logic        o_sat;

  logic        o2_valid;
  logic [31:0] o2_data;
  logic        o2_last;
  logic        o2_overflow;
  logic        o2_sat;

  int errCount;
  int checkCount;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } obs_t;

  typedef struct {
    logic [27:0] re;
    logic [27:0] im;
    logic [31:0] exp0;
    logic [31:0] exp1;
  } vec_t;

  obs_t obsQ[$];
  obs_t obs2Q[$];
  obs_t mon1;
  obs_t mon2;
  vec_t tbl[8];

  ifft_frame_packer dut (
    .i_clk(clk), .i_reset(i_reset), .i_ce(i_ce), .i_sample(i_sample),
    .i_sync(i_sync), .i_clear(i_clear), .o_valid(o_valid), .i_ready(i_ready),
    .o_data(o_data), .o_last(o_last), .o_overflow(o_overflow), .o_sat(o_sat)
  );

  ifft_frame_packer #(.SHIFT(1)) dut2 (
    .i_clk(clk), .i_reset(i_reset), .i_ce(i_ce), .i_sample(i_sample),
    .i_sync(i_sync), .i_clear(i_clear), .o_valid(o2_valid), .i_ready(i_ready),
    .o_data(o2_data), .o_last(o2_last), .o_overflow(o2_overflow), .o_sat(o2_sat)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Record every word the consumer takes. Inputs change 2 units after the
  // rising edge, so the falling edge sees settled handshake signals.
  always @(negedge clk) begin
    if (o_valid && i_ready) begin
      mon1.data = o_data;
      mon1.last = o_last;
      obsQ.push_back(mon1);
    end
    if (o2_valid && i_ready) begin
      mon2.data = o2_data;
      mon2.last = o2_last;
      obs2Q.push_back(mon2);
    end
  end

  task automatic applyStimulus(input logic ce, input logic sync,
                               input logic [27:0] re, input logic [27:0] im,
                               input logic clr);
    @(posedge clk);
    #2;
    i_ce     = ce;
    i_sync   = sync;
    i_sample = {re, im};
    i_clear  = clr;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 28'h0, 28'h0, 1'b0);
    end
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic resetDut();
    i_reset = 1'b1;
    idle(2);
    i_reset = 1'b0;
    obsQ.delete();
    obs2Q.delete();
  endtask

  initial begin
    int n;
    int idx;
    logic [27:0] v;
    logic [15:0] h;

    errCount   = 0;
    checkCount = 0;
    i_reset    = 1'b1;
    i_ce       = 1'b0;
    i_sync     = 1'b0;
    i_sample   = '0;
    i_clear    = 1'b0;
    i_ready    = 1'b1;

    // Rounding rows (0-4) then saturation rows (5-7). exp0 is the SHIFT=0
    // result, exp1 the SHIFT=1 result.
    tbl[0] = '{28'h0001800, 28'h0000000, 32'h0002_0000, 32'h0003_0000};
    tbl[1] = '{28'h0002800, 28'h0000000, 32'h0002_0000, 32'h0005_0000};
    tbl[2] = '{28'h0003800, 28'h0000000, 32'h0004_0000, 32'h0007_0000};
    tbl[3] = '{28'hFFFE800, 28'h0000000, 32'hFFFE_0000, 32'hFFFD_0000};
    tbl[4] = '{28'h00017FF, 28'h0000000, 32'h0001_0000, 32'h0003_0000};
    tbl[5] = '{28'h7FFFFFF, 28'h0000000, 32'h7FFF_0000, 32'h7FFF_0000};
    tbl[6] = '{28'h0000000, 28'h8000000, 32'h0000_8000, 32'h0000_8000};
    tbl[7] = '{28'h4000000, 28'h0000000, 32'h4000_0000, 32'h7FFF_0000};

    // Full frame: k<<12 / -(k<<12) maps to {k, -k}, last only on 2047.
    $display("[TB] full frame");
    idle(1);
    checkOutput("reset_valid", {63'd0, o_valid}, 64'd0);
    checkOutput("reset_data", {32'd0, o_data}, 64'd0);
    checkOutput("reset_flags", {62'd0, o_overflow, o_sat}, 64'd0);
    resetDut();
    for (int k = 0; k < 2048; k++) begin
      v = 28'(k << 12);
      applyStimulus(1'b1, k == 0, v, -v, 1'b0);
      if (k == 2) checkOutput("latency_n1", {63'd0, o_valid}, 64'd0);
      if (k == 3) checkOutput("latency_n2", {63'd0, o_valid}, 64'd1);
    end
    idle(10);
    checkOutput("t1_count", 64'(obsQ.size()), 64'd2048);
    n = (obsQ.size() < 2048) ? obsQ.size() : 2048;
    for (int k = 0; k < n; k++) begin
      h = 16'(k);
      checkOutput($sformatf("t1_data[%0d]", k), {32'd0, obsQ[k].data}, {32'd0, h, -h});
      checkOutput($sformatf("t1_last[%0d]", k), {63'd0, obsQ[k].last}, {63'd0, k == 2047});
    end
    checkOutput("t1_flags", {62'd0, o_overflow, o_sat}, 64'd0);

    // Samples before the first sync are discarded.
    $display("[TB] wait for sync");
    resetDut();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 1'b0, 28'h0005000, 28'h0005000, 1'b0);
    end
    applyStimulus(1'b1, 1'b1, 28'h0001000, 28'h0002000, 1'b0);
    idle(6);
    checkOutput("t2_count", 64'(obsQ.size()), 64'd1);
    if (obsQ.size() > 0) begin
      checkOutput("t2_data", {32'd0, obsQ[0].data}, 64'h0001_0002);
      checkOutput("t2_last", {63'd0, obsQ[0].last}, 64'd0);
    end

    // Rounding and saturation from the vector table.
    $display("[TB] rounding and saturation");
    resetDut();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, i == 0, tbl[i].re, tbl[i].im, 1'b0);
    end
    idle(5);
    checkOutput("t3_sat", {63'd0, o_sat}, 64'd0);
    checkOutput("t3_sat_shift", {63'd0, o2_sat}, 64'd0);
    for (int i = 5; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, tbl[i].re, tbl[i].im, 1'b0);
    end
    idle(5);
    checkOutput("t4_sat", {63'd0, o_sat}, 64'd1);
    checkOutput("t4_sat_shift", {63'd0, o2_sat}, 64'd1);
    checkOutput("t4_count", 64'(obsQ.size()), 64'd8);
    checkOutput("t4_count_shift", 64'(obs2Q.size()), 64'd8);
    n = (obsQ.size() < 8) ? obsQ.size() : 8;
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("t34_data[%0d]", i), {32'd0, obsQ[i].data}, {32'd0, tbl[i].exp0});
    end
    n = (obs2Q.size() < 8) ? obs2Q.size() : 8;
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("t34_shift_data[%0d]", i), {32'd0, obs2Q[i].data}, {32'd0, tbl[i].exp1});
    end
    applyStimulus(1'b0, 1'b0, 28'h0, 28'h0, 1'b1);
    idle(1);
    checkOutput("t4_clear", {63'd0, o_sat}, 64'd0);
    checkOutput("t4_clear_shift", {63'd0, o2_sat}, 64'd0);
    applyStimulus(1'b1, 1'b0, 28'h7FFFFFF, 28'h0, 1'b1);
    idle(2);
    checkOutput("t4_clear_priority", {63'd0, o_sat}, 64'd0);

    // Backpressure: 16 buffered, 4 dropped, stall-stable output, then drain
    // and finish the frame to see o_last on index 2047.
    $display("[TB] backpressure");
    resetDut();
    i_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b1, k == 0, 28'((k + 1) << 12), 28'h0, 1'b0);
      if (k >= 3) begin
        checkOutput($sformatf("t5_stall_valid[%0d]", k), {63'd0, o_valid}, 64'd1);
        checkOutput($sformatf("t5_stall_data[%0d]", k), {32'd0, o_data}, 64'h0001_0000);
      end
    end
    idle(3);
    checkOutput("t5_overflow", {63'd0, o_overflow}, 64'd1);
    checkOutput("t5_hold_data", {32'd0, o_data}, 64'h0001_0000);
    i_ready = 1'b1;
    idle(20);
    for (int k = 20; k < 2048; k++) begin
      applyStimulus(1'b1, 1'b0, 28'((k + 1) << 12), 28'h0, 1'b0);
    end
    idle(10);
    checkOutput("t5_count", 64'(obsQ.size()), 64'd2044);
    n = (obsQ.size() < 2044) ? obsQ.size() : 2044;
    for (int i = 0; i < n; i++) begin
      idx = (i < 16) ? i : i + 4;
      checkOutput($sformatf("t5_data[%0d]", idx), {32'd0, obsQ[i].data}, {32'd0, 16'(idx + 1), 16'd0});
      checkOutput($sformatf("t5_last[%0d]", idx), {63'd0, obsQ[i].last}, {63'd0, idx == 2047});
    end

    // Asynchronous reset mid-frame, then resynchronisation.
    $display("[TB] async reset mid-frame");
    obsQ.delete();
    for (int k = 0; k <= 700; k++) begin
      applyStimulus(1'b1, k == 0, 28'(k << 12), 28'h0, 1'b0);
    end
    checkOutput("t6_pre_valid", {63'd0, o_valid}, 64'd1);
    checkOutput("t6_pre_overflow", {63'd0, o_overflow}, 64'd1);
    #1;
    i_reset = 1'b1;
    #1;
    checkOutput("t6_rst_valid", {63'd0, o_valid}, 64'd0);
    checkOutput("t6_rst_data", {32'd0, o_data}, 64'd0);
    checkOutput("t6_rst_last", {63'd0, o_last}, 64'd0);
    checkOutput("t6_rst_flags", {62'd0, o_overflow, o_sat}, 64'd0);
    idle(1);
    i_reset = 1'b0;
    obsQ.delete();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 1'b0, 28'h0005000, 28'h0005000, 1'b0);
    end
    for (int k = 0; k < 2048; k++) begin
      applyStimulus(1'b1, k == 0, 28'(k << 12), 28'h0, 1'b0);
    end
    idle(10);
    checkOutput("t6_count", 64'(obsQ.size()), 64'd2048);
    n = (obsQ.size() < 2048) ? obsQ.size() : 2048;
    for (int k = 0; k < n; k++) begin
      checkOutput($sformatf("t6_data[%0d]", k), {32'd0, obsQ[k].data}, {32'd0, 16'(k), 16'd0});
      checkOutput($sformatf("t6_last[%0d]", k), {63'd0, obsQ[k].last}, {63'd0, k == 2047});
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/ifft_frame_packer.md
Name: ifft_frame_packer

Overview:
- Sits directly downstream of the 2048-point inverse FFT core.
- Consumes the core's i_ce-strobed, bit-reversed complex output stream and its frame sync.
- Rounds and saturates each component from 28 to 16 bits, numbers samples within the frame, and buffers them in a small FIFO.
- Presents the frames on a valid/ready stream with a last-sample marker, for the playback/DMA side.

Parameters:
IWIDTH, 28, input component width (signed), real in upper half of i_sample
OWIDTH, 16, output component width (signed); must be < IWIDTH
SHIFT, 0, left gain shift applied before rounding (0..IWIDTH-OWIDTH)
LGSIZE, 11, log2 of frame length
LGFIFO, 4, log2 of FIFO depth

Ports:
i_clk  in  1  clock, all logic on rising edge
i_reset  in  1  asynchronous, active-high reset
i_ce  in  1  input sample strobe (same strobe that drives the FFT core)
i_sample  in  2*IWIDTH  {real, imag}, two's complement
i_sync  in  1  high with i_ce on sample 0 of a frame
i_clear  in  1  synchronous clear of sticky flags
o_valid  out  1  output word available
i_ready  in  1  consumer accepts word when o_valid && i_ready
o_data  out  2*OWIDTH  {real, imag} rounded/saturated
o_last  out  1  qualifies o_data as sample 2^LGSIZE-1 of its frame
o_overflow  out  1  sticky: a sample was dropped because FIFO was full
o_sat  out  1  sticky: any component saturated

Behaviour:
Reset:
- On i_reset (async), all outputs go to 0.
- FSM goes to S_WAIT; FIFO is empty; sample counter = 0; rounding pipeline is invalidated.
- A reset mid-frame discards everything. Output resumes only after the next i_sync.

FSM:
- S_WAIT: samples with i_ce && !i_sync are discarded. i_ce && i_sync accepts that sample as index 0, and the FSM goes to S_RUN.
- S_RUN: every i_ce sample is accepted. Counter advances 0..2^LGSIZE-1 and wraps to 0.
- i_ce && i_sync in S_RUN forces that sample to index 0, even mid-frame. The previous frame then ends without o_last.
- Index 2^LGSIZE-1 tags last=1.

Arithmetic, per component (identical for real and imag):
- t = v * 2^SHIFT, held at full width (no loss).
- Drop D = IWIDTH-OWIDTH low bits with convergent rounding (round half to even): add (2^(D-1)-1) + bit D of t, then arithmetic shift right by D.
- If the result exceeds the OWIDTH signed range, clamp to +2^(OWIDTH-1)-1 or -2^(OWIDTH-1), and set o_sat.

Pipeline:
- Stage 1: register the rounded data, last tag and valid at the edge where i_ce is sampled.
- Stage 2: push to the FIFO on the following edge.
- FIFO is first-word-fall-through with a registered output.
- Latency: with an empty FIFO, a sample accepted at edge N gives o_valid=1 after edge N+2.

FIFO / handshake:
- Depth 2^LGFIFO, entries hold {data, last}. Order is preserved.
- Push while full: full is evaluated before any same-cycle pop. The word is dropped and o_overflow is set. The counter still advances, so later samples keep their correct indices.
- Pop occurs on o_valid && i_ready.
- o_data and o_last stay stable while o_valid && !i_ready.
- Push and pop in the same cycle when not full: occupancy unchanged.
- i_ready is not used combinationally to gate a push.

Flags:
- o_overflow and o_sat hold until i_clear or reset.
- i_clear has priority over a same-cycle set.

Test Plan:
1. Reset, i_ready=1, 2048 continuous i_ce with i_sync on first; sample k real=k<<12, imag=-(k<<12).
   -> o_data = {k, -k}; o_last only at k=2047; first o_valid 2 cycles after first i_ce; no flags set.
2. Five i_ce samples with i_sync=0, then a sync sample of value {0x1000, 0x2000}.
   -> First output is {1, 2}; the five earlier samples never appear.
3. Rounding, SHIFT=0, real inputs 0x1800, 0x2800, 0x3800, -0x1800, 0x17FF.
   -> Outputs 2, 2, 4, -2, 1; o_sat=0.
4. Saturation: real=0x7FFFFFF, then imag=-0x8000000; separately SHIFT=1 with real=0x4000000.
   -> 0x7FFF, 0x8000, 0x7FFF; o_sat=1. i_clear pulse -> o_sat=0.
5. Backpressure, LGFIFO=4: i_ready=0, 20 sequential samples after sync.
   -> 16 words buffered, o_overflow=1. After i_ready=1, indices 0..15 emerge in order with o_data stable while stalled. Index 2047 of that frame still carries o_last.
6. Assert i_reset asynchronously (between edges) at sample 700 of a frame.
   -> o_valid/o_data/o_last/flags go 0 immediately. Samples arriving without i_sync after release are ignored; the next sync restarts at index 0.
